way_sel_pipe: RTL and testbench
===============================

Name: way_sel_pipe

Overview:
- Parametrised, registered N-way read-select stage for the set-associative cache datapath.
- Takes the full entry of every way in the indexed set and performs the tag compare.
- Produces hit, hit way, selected line data, dirty/LRU state and a replacement victim.
- Sits between the tag/data arrays and the cache controller FSM, behind a valid/ready handshake; also supports a forced one-hot way read for writeback/eviction.

Parameters:
- WAYS, 4, number of ways (2..16).
- LINE_SIZE_BYTES, 4, line data bytes per way.
- TAG_BITS, 18, tag width.
- LRU_BITS, 1, LRU field width per way.
- ENTRY_W, derived = 3 + LRU_BITS - 1 + TAG_BITS + LINE_SIZE_BYTES*8. Entry layout, MSB first: valid(1), lru(LRU_BITS), dirty(1), tag, data.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  stage can accept a request.
- i_entries  in  WAYS*ENTRY_W  way w at bits [w*ENTRY_W +: ENTRY_W].
- i_tag  in  TAG_BITS  lookup tag.
- i_force  in  1  1 = bypass tag compare and read way i_sel.
- i_sel  in  WAYS  one-hot forced way.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_hit  out  1  lookup hit (forced read: selected way valid).
- o_hit_way  out  WAYS  one-hot selected way, 0 on miss.
- o_data  out  LINE_SIZE_BYTES*8  selected line data.
- o_dirty  out  1  dirty bit of selected way.
- o_victim_way  out  WAYS  one-hot replacement candidate.
- o_sel_err  out  1  forced i_sel not one-hot.
- o_multi_hit  out  1  more than one way matched (see Optional Feature).

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0, all result registers 0, o_ready=1 once reset is released. Reset mid-transfer drops the held result.
- Handshake:
  - o_ready = !o_valid | i_ready.
  - A request is accepted on a rising edge with i_valid & o_ready.
  - Latency is 1 cycle: accepted at edge N, result visible after edge N, o_valid=1.
  - The result is held stable while o_valid & !i_ready.
  - Back-to-back accepts are allowed, giving full throughput.
  - o_valid clears only on i_ready with no new accept.
- Lookup (i_force=0):
  - match[w] = valid[w] & (tag[w]==i_tag).
  - o_hit = |match.
  - The selected way is the lowest-index match; o_hit_way is one-hot of it.
  - o_data and o_dirty come from that way.
  - Miss: o_hit_way=0, o_data=0, o_dirty=0.
- Forced read (i_force=1):
  - Tag is ignored.
  - If i_sel is one-hot: select that way, o_hit = its valid bit, o_hit_way = i_sel.
  - Otherwise (zero or multiple bits): o_data=0, o_hit=0, o_hit_way=0, o_sel_err=1. Output is never held from the previous selection.
- Victim (computed on every accept):
  - Lowest-index invalid way.
  - Else lowest-index way with lru field == 0.
  - Else way 0.
  - Always exactly one bit set.
- All result fields (o_hit, o_hit_way, o_data, o_dirty, o_victim_way, o_sel_err, o_multi_hit) are registered together on accept only.
- All selection logic is combinational before the register. No latches: every output bit is defined for every input combination.

Optional Feature:
- Macro: WAY_SEL_MULTIHIT_CHECK_EN.
- Defined:
  - o_multi_hit is registered on accept as (popcount(match) > 1) for lookups, 0 for forced reads.
  - A sticky internal flag is also set and ORed into o_multi_hit on all later results until reset.
  - Data still comes from the lowest-index match.
- Undefined: o_multi_hit tied 0; no popcount or sticky logic is synthesised.

Test Plan:
- Reset/idle: hold i_rst_n=0, drive random inputs -> o_valid=0, o_ready=1, all outputs 0. Assert i_rst_n=0 while o_valid=1 -> o_valid drops immediately (async).
- Hit way 2 (WAYS=4): ways 0..3 valid, tags 0x100..0x103, data 0xA0..0xA3, way 2 dirty; i_tag=0x102, i_valid=1, i_ready=1 -> next cycle o_valid=1, o_hit=1, o_hit_way=4'b0100, o_data=0xA2, o_dirty=1.
- Miss/victim: way 1 invalid, i_tag=0x3FFFF matches nothing -> o_hit=0, o_hit_way=0, o_data=0, o_victim_way=4'b0010. All valid with lru={1,1,0,1} for ways 0..3 -> o_victim_way=4'b0100.
- Forced read: i_force=1, i_sel=4'b1000 -> o_data = way 3 data, o_hit_way=4'b1000. i_sel=4'b0110 -> o_sel_err=1, o_data=0. i_sel=0 -> o_sel_err=1.
- Backpressure: three back-to-back requests with i_ready=0 for 3 cycles after the first result -> o_ready=0, first result held bit-stable. Then i_ready=1 -> results 2 and 3 follow on consecutive cycles, none lost or duplicated.
- Multi-hit (macro defined): ways 1 and 3 both valid with tag 0x55, i_tag=0x55 -> o_hit_way=4'b0010, o_multi_hit=1. Next request is a clean hit -> o_multi_hit stays 1 (sticky) until reset. Macro undefined -> o_multi_hit=0.

Source files
------------

// File: rtl/way_sel_pipe.sv
// rtl/way_sel_pipe.sv - registered N-way tag compare / way select stage with victim choice.
// Optional multi-hit detection enabled by defining WAY_SEL_MULTIHIT_CHECK_EN.
module way_sel_pipe #(
    parameter int WAYS            = 4,
    parameter int LINE_SIZE_BYTES = 4,
    parameter int TAG_BITS        = 18,
    parameter int LRU_BITS        = 1,
    localparam int DATA_W         = LINE_SIZE_BYTES * 8,
    localparam int ENTRY_W        = 3 + LRU_BITS - 1 + TAG_BITS + DATA_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [WAYS*ENTRY_W-1:0] i_entries,
    input  logic [TAG_BITS-1:0]     i_tag,
    input  logic                    i_force,
    input  logic [WAYS-1:0]         i_sel,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_hit,
    output logic [WAYS-1:0]         o_hit_way,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_dirty,
    output logic [WAYS-1:0]         o_victim_way,
    output logic                    o_sel_err,
    output logic                    o_multi_hit
);

    logic [WAYS-1:0]   vld, lru_zero, dty, match, sel_way, victim;
    logic [DATA_W-1:0] sel_data;
    logic              sel_dirty, sel_hit, sel_err, sel_onehot;
    logic              m_found, inv_found, lru_found;
    logic              accept;

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    assign sel_onehot = (i_sel != '0) && ((i_sel & (i_sel - WAYS'(1))) == '0);

    // Field extraction per way; entry layout from LSB is data, tag, dirty, lru, valid.
    always_comb begin
        vld      = '0;
        lru_zero = '0;
        dty      = '0;
        match    = '0;
        for (int w = 0; w < WAYS; w++) begin
            vld[w]      = i_entries[w*ENTRY_W + ENTRY_W - 1];
            lru_zero[w] = (i_entries[w*ENTRY_W + DATA_W + TAG_BITS + 1 +: LRU_BITS] == '0);
            dty[w]      = i_entries[w*ENTRY_W + DATA_W + TAG_BITS];
            match[w]    = vld[w] && (i_entries[w*ENTRY_W + DATA_W +: TAG_BITS] == i_tag);
        end
    end

    always_comb begin
        sel_way = '0;
        sel_hit = 1'b0;
        sel_err = 1'b0;
        m_found = 1'b0;
        if (i_force) begin
            if (sel_onehot) begin
                sel_way = i_sel;
                sel_hit = |(i_sel & vld);
            end else begin
                sel_err = 1'b1;
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (match[w] && !m_found) begin
                    sel_way[w] = 1'b1;
                    m_found    = 1'b1;
                end
            end
            sel_hit = m_found;
        end
    end

    // sel_way is one-hot or zero, so an AND-OR mux yields zero data on miss/error.
    always_comb begin
        sel_data  = '0;
        sel_dirty = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            sel_data  = sel_data | (i_entries[w*ENTRY_W +: DATA_W] & {DATA_W{sel_way[w]}});
            sel_dirty = sel_dirty | (dty[w] & sel_way[w]);
        end
    end

    always_comb begin
        victim    = '0;
        inv_found = 1'b0;
        lru_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vld[w] && !inv_found) begin
                victim    = '0;
                victim[w] = 1'b1;
                inv_found = 1'b1;
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (lru_zero[w] && !lru_found) begin
                    victim[w] = 1'b1;
                    lru_found = 1'b1;
                end
            end
            if (!lru_found) begin
                victim[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_hit        <= 1'b0;
            o_hit_way    <= '0;
            o_data       <= '0;
            o_dirty      <= 1'b0;
            o_victim_way <= '0;
            o_sel_err    <= 1'b0;
        end else if (accept) begin
            o_valid      <= 1'b1;
            o_hit        <= sel_hit;
            o_hit_way    <= sel_way;
            o_data       <= sel_data;
            o_dirty      <= sel_dirty;
            o_victim_way <= victim;
            o_sel_err    <= sel_err;
        end else if (i_ready) begin
            o_valid      <= 1'b0;
        end
    end

`ifdef WAY_SEL_MULTIHIT_CHECK_EN
    logic [4:0] hit_cnt;
    logic       multi_now, multi_sticky;

    always_comb begin
        hit_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_cnt = hit_cnt + {4'b0000, match[w]};
        end
        multi_now = !i_force && (hit_cnt > 5'd1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            multi_sticky <= 1'b0;
            o_multi_hit  <= 1'b0;
        end else if (accept) begin
            multi_sticky <= multi_sticky || multi_now;
            o_multi_hit  <= multi_sticky || multi_now;
        end
    end
`else
    assign o_multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_way_sel_pipe.sv
// tb/tb_way_sel_pipe.sv - directed self-checking bench for way_sel_pipe (WAYS=4 defaults).
module tb_way_sel_pipe;

    localparam int WAYS = 4;
    localparam int EW   = 53;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid, i_force, i_ready;
    logic              o_ready, o_valid, o_hit, o_dirty, o_sel_err, o_multi_hit;
    logic [17:0]       i_tag;
    logic [3:0]        i_sel, o_hit_way, o_victim_way;
    logic [31:0]       o_data;
    logic [EW-1:0]     ent [WAYS];
    logic [WAYS*EW-1:0] entries;

    int checks   = 0;
    int failures = 0;

`ifdef WAY_SEL_MULTIHIT_CHECK_EN
    localparam logic MH = 1'b1;
`else
    localparam logic MH = 1'b0;
`endif

    assign entries = {ent[3], ent[2], ent[1], ent[0]};

    always #5 clk = ~clk;

    way_sel_pipe dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_entries    (entries),
        .i_tag        (i_tag),
        .i_force      (i_force),
        .i_sel        (i_sel),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_hit        (o_hit),
        .o_hit_way    (o_hit_way),
        .o_data       (o_data),
        .o_dirty      (o_dirty),
        .o_victim_way (o_victim_way),
        .o_sel_err    (o_sel_err),
        .o_multi_hit  (o_multi_hit)
    );

    function automatic logic [EW-1:0] mk(input logic v, input logic l, input logic d,
                                         input logic [17:0] t, input logic [31:0] dat);
        return {v, l, d, t, dat};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic base_set();
        for (int w = 0; w < WAYS; w++)
            ent[w] = mk(1'b1, 1'b1, (w == 2), 18'h100 + 18'(w), 32'hA0 + 32'(w));
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_force = 1'b0;
        i_ready = 1'b1;
        i_sel   = 4'b0001;
        i_tag   = 18'h0;
        // Random inputs while held in reset
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < WAYS; w++) ent[w] = EW'({$urandom, $urandom});
            i_tag = 18'($urandom);
            i_sel = 4'($urandom);
            tick();
        end
        chk("rst_valid",  64'(o_valid), 64'h0);
        chk("rst_ready",  64'(o_ready), 64'h1);
        chk("rst_hit",    64'(o_hit), 64'h0);
        chk("rst_hitway", 64'(o_hit_way), 64'h0);
        chk("rst_data",   64'(o_data), 64'h0);
        chk("rst_victim", 64'(o_victim_way), 64'h0);
        chk("rst_selerr", 64'(o_sel_err), 64'h0);
        chk("rst_multi",  64'(o_multi_hit), 64'h0);
        rst_n = 1'b1;

        // Hit on way 2
        base_set();
        i_tag = 18'h102;
        i_sel = 4'b0000;
        tick();
        chk("hit_valid",  64'(o_valid), 64'h1);
        chk("hit_hit",    64'(o_hit), 64'h1);
        chk("hit_way",    64'(o_hit_way), 64'b0100);
        chk("hit_data",   64'(o_data), 64'hA2);
        chk("hit_dirty",  64'(o_dirty), 64'h1);
        chk("hit_victim", 64'(o_victim_way), 64'b0001);
        chk("hit_multi",  64'(o_multi_hit), 64'h0);

        // Miss, way 1 invalid -> victim way 1
        ent[1] = mk(1'b0, 1'b1, 1'b0, 18'h101, 32'hA1);
        i_tag  = 18'h3FFFF;
        tick();
        chk("miss_hit",    64'(o_hit), 64'h0);
        chk("miss_way",    64'(o_hit_way), 64'h0);
        chk("miss_data",   64'(o_data), 64'h0);
        chk("miss_dirty",  64'(o_dirty), 64'h0);
        chk("miss_victim", 64'(o_victim_way), 64'b0010);

        // All valid, lru = {1,1,0,1} -> victim way 2
        base_set();
        ent[2][51] = 1'b0;
        tick();
        chk("lru_victim", 64'(o_victim_way), 64'b0100);
        chk("lru_hit",    64'(o_hit), 64'h0);

        // Forced reads
        base_set();
        i_force = 1'b1;
        i_sel   = 4'b1000;
        tick();
        chk("frc3_data",   64'(o_data), 64'hA3);
        chk("frc3_way",    64'(o_hit_way), 64'b1000);
        chk("frc3_hit",    64'(o_hit), 64'h1);
        chk("frc3_selerr", 64'(o_sel_err), 64'h0);
        ent[1] = mk(1'b0, 1'b1, 1'b0, 18'h101, 32'hA1);
        i_sel  = 4'b0010;
        tick();
        chk("frc_inv_hit",  64'(o_hit), 64'h0);
        chk("frc_inv_way",  64'(o_hit_way), 64'b0010);
        chk("frc_inv_data", 64'(o_data), 64'hA1);
        i_sel = 4'b0110;
        tick();
        chk("frc_multi_err",  64'(o_sel_err), 64'h1);
        chk("frc_multi_data", 64'(o_data), 64'h0);
        chk("frc_multi_hit",  64'(o_hit), 64'h0);
        chk("frc_multi_way",  64'(o_hit_way), 64'h0);
        i_sel = 4'b0000;
        tick();
        chk("frc_zero_err",  64'(o_sel_err), 64'h1);
        chk("frc_zero_data", 64'(o_data), 64'h0);
        i_force = 1'b0;

        // Backpressure: A accepted, B and C wait behind i_ready=0
        base_set();
        i_tag = 18'h100;
        tick();
        chk("bp_a_data", 64'(o_data), 64'hA0);
        i_ready = 1'b0;
        i_tag   = 18'h101;
        #1;
        chk("bp_ready_low", 64'(o_ready), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_valid", 64'(o_valid), 64'h1);
            chk("bp_hold_data",  64'(o_data), 64'hA0);
            chk("bp_hold_way",   64'(o_hit_way), 64'b0001);
            chk("bp_hold_ready", 64'(o_ready), 64'h0);
        end
        i_ready = 1'b1;
        #1;
        chk("bp_ready_high", 64'(o_ready), 64'h1);
        tick();
        chk("bp_b_valid", 64'(o_valid), 64'h1);
        chk("bp_b_data",  64'(o_data), 64'hA1);
        i_tag = 18'h103;
        tick();
        chk("bp_c_valid", 64'(o_valid), 64'h1);
        chk("bp_c_data",  64'(o_data), 64'hA3);
        i_valid = 1'b0;
        tick();
        chk("bp_drain_valid", 64'(o_valid), 64'h0);

        // Multi-hit: ways 1 and 3 share tag 0x55
        ent[1]  = mk(1'b1, 1'b1, 1'b0, 18'h55, 32'hA1);
        ent[3]  = mk(1'b1, 1'b1, 1'b1, 18'h55, 32'hA3);
        i_tag   = 18'h55;
        i_valid = 1'b1;
        tick();
        chk("mh_way",   64'(o_hit_way), 64'b0010);
        chk("mh_data",  64'(o_data), 64'hA1);
        chk("mh_dirty", 64'(o_dirty), 64'h0);
        chk("mh_flag",  64'(o_multi_hit), 64'(MH));
        i_tag = 18'h100;
        tick();
        chk("mh_clean_way",   64'(o_hit_way), 64'b0001);
        chk("mh_sticky_flag", 64'(o_multi_hit), 64'(MH));

        // Asynchronous reset while a result is held
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'h0);
        chk("arst_data",  64'(o_data), 64'h0);
        chk("arst_multi", 64'(o_multi_hit), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 64'(o_valid), 64'h1);
        chk("post_rst_data",  64'(o_data), 64'hA0);
        chk("post_rst_multi", 64'(o_multi_hit), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
